// File: rtl/zic_ack_if.sv
// zic_ack_if: generator/core handshake bundle for the ZIC acknowledge controller.
interface zic_ack_if;
    logic       irq_req_i;
    logic       irq_id_valid_i;
    logic [7:0] irq_id_i;
    logic [7:0] irq_lvl_i;
    logic       core_ack_i;
    logic       core_eoi_i;
    logic       core_irq_o;
    logic [7:0] core_irq_id_o;
    logic [7:0] active_lvl_o;
    logic [7:0] active_id_o;
    logic       claim_o;
    logic [7:0] claim_id_o;
    logic       eoi_valid_o;
    logic [3:0] nest_depth_o;
    logic       err_o;
    logic       timeout_o;
    modport slave (
        input  irq_req_i, irq_id_valid_i, irq_id_i, irq_lvl_i, core_ack_i, core_eoi_i,
        output core_irq_o, core_irq_id_o, active_lvl_o, active_id_o, claim_o, claim_id_o,
               eoi_valid_o, nest_depth_o, err_o, timeout_o
    );
    modport master (
        output irq_req_i, irq_id_valid_i, irq_id_i, irq_lvl_i, core_ack_i, core_eoi_i,
        input  core_irq_o, core_irq_id_o, active_lvl_o, active_id_o, claim_o, claim_id_o,
               eoi_valid_o, nest_depth_o, err_o, timeout_o
    );
endinterface

// File: rtl/zic_ack_ctrl.sv
// zic_ack_ctrl: core-side claim/EOI responder with active-level nesting stack.
// Optional acknowledge timeout enabled by defining ZIC_ACK_TIMEOUT_EN.
module zic_ack_ctrl #(
    parameter int NEST_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic      zic_clk,
    input  logic      zic_rst,
    input  logic      wdt_reset_i,
    zic_ack_if.slave  bus
);
    localparam int AW = NEST_DEPTH > 1 ? $clog2(NEST_DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, REQ, CLAIM} state_t;
    if (NEST_DEPTH < 1 || NEST_DEPTH > 8 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_param
        $error("zic_ack_ctrl: parameter out of range");
    end
    state_t     state_q, state_d;
    logic       irq_q, irq_d, claim_q, claim_d, eoi_q, eoi_d, err_q, err_d;
    logic [7:0] id_q, id_d, lvl_q, lvl_d, act_id_q, act_id_d, act_lvl_q, act_lvl_d;
    logic [7:0] claim_id_q, claim_id_d;
    logic [3:0] depth_q, depth_d;
    logic [7:0] stk_lvl_q [NEST_DEPTH];
    logic [7:0] stk_id_q  [NEST_DEPTH];
    logic       push, pop, stk_clr, tmo_hit;
    logic [AW-1:0] top_idx, new_idx;
    assign new_idx = AW'(depth_q);
    assign top_idx = AW'(depth_q - 4'd1);
`ifdef ZIC_ACK_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       tmo_q;
    assign tmo_hit = cnt_q == 8'(TIMEOUT_CYC - 1);
    always_ff @(posedge zic_clk or negedge zic_rst) begin
        if (!zic_rst) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= (wdt_reset_i || state_q != REQ) ? 8'd0 : cnt_q + 8'd1;
            tmo_q <= !wdt_reset_i && state_q == REQ && !bus.core_ack_i && bus.irq_req_i && tmo_hit;
        end
    end
    assign bus.timeout_o = tmo_q;
`else
    assign tmo_hit       = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif
    always_comb begin
        state_d    = state_q;
        irq_d      = irq_q;
        id_d       = id_q;
        lvl_d      = lvl_q;
        act_id_d   = act_id_q;
        act_lvl_d  = act_lvl_q;
        claim_id_d = claim_id_q;
        claim_d    = 1'b0;
        eoi_d      = 1'b0;
        depth_d    = depth_q;
        push       = 1'b0;
        stk_clr    = wdt_reset_i;
        pop        = bus.core_eoi_i && depth_q != 4'd0;
        err_d      = err_q | (bus.core_eoi_i && depth_q == 4'd0);
        if (pop) begin
            act_lvl_d = stk_lvl_q[top_idx];
            act_id_d  = stk_id_q[top_idx];
            depth_d   = depth_q - 4'd1;
            eoi_d     = 1'b1;
        end
        case (state_q)
            IDLE: if (bus.irq_req_i && bus.irq_id_valid_i && depth_q < 4'(NEST_DEPTH)) begin
                state_d = REQ;
                irq_d   = 1'b1;
                id_d    = bus.irq_id_i;
                lvl_d   = bus.irq_lvl_i;
            end
            REQ: if (bus.core_ack_i) begin
                // Ack with a same-cycle EOI: pop then push leaves the stack untouched.
                push       = 1'b1;
                state_d    = CLAIM;
                irq_d      = 1'b0;
                claim_d    = 1'b1;
                claim_id_d = id_q;
                act_lvl_d  = lvl_q;
                act_id_d   = id_q;
                depth_d    = pop ? depth_q : depth_q + 4'd1;
            end else if (!bus.irq_req_i || tmo_hit) begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end else if (bus.irq_id_i != id_q) begin
                id_d  = bus.irq_id_i;
                lvl_d = bus.irq_lvl_i;
            end
            default: state_d = IDLE;
        endcase
        if (wdt_reset_i) begin
            state_d    = IDLE;
            irq_d      = 1'b0;
            id_d       = '0;
            lvl_d      = '0;
            act_id_d   = '0;
            act_lvl_d  = '0;
            claim_id_d = '0;
            claim_d    = 1'b0;
            eoi_d      = 1'b0;
            err_d      = 1'b0;
            depth_d    = '0;
            push       = 1'b0;
        end
    end
    always_ff @(posedge zic_clk or negedge zic_rst) begin
        if (!zic_rst) begin
            state_q    <= IDLE;
            irq_q      <= 1'b0;
            id_q       <= '0;
            lvl_q      <= '0;
            act_id_q   <= '0;
            act_lvl_q  <= '0;
            claim_id_q <= '0;
            claim_q    <= 1'b0;
            eoi_q      <= 1'b0;
            err_q      <= 1'b0;
            depth_q    <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stk_lvl_q[i] <= '0;
                stk_id_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            id_q       <= id_d;
            lvl_q      <= lvl_d;
            act_id_q   <= act_id_d;
            act_lvl_q  <= act_lvl_d;
            claim_id_q <= claim_id_d;
            claim_q    <= claim_d;
            eoi_q      <= eoi_d;
            err_q      <= err_d;
            depth_q    <= depth_d;
            if (stk_clr) begin
                for (int i = 0; i < NEST_DEPTH; i++) begin
                    stk_lvl_q[i] <= '0;
                    stk_id_q[i]  <= '0;
                end
            end else if (push && !pop) begin
                stk_lvl_q[new_idx] <= act_lvl_q;
                stk_id_q[new_idx]  <= act_id_q;
            end
        end
    end
    assign bus.core_irq_o    = irq_q;
    assign bus.core_irq_id_o = id_q;
    assign bus.active_lvl_o  = act_lvl_q;
    assign bus.active_id_o   = act_id_q;
    assign bus.claim_o       = claim_q;
    assign bus.claim_id_o    = claim_id_q;
    assign bus.eoi_valid_o   = eoi_q;
    assign bus.nest_depth_o  = depth_q;
    assign bus.err_o         = err_q;
endmodule

// File: doc/zic_ack_ctrl.md
Name: zic_ack_ctrl

Overview:
Core-side responder for the ZIC interrupt request generator.
- Registers the generator's request/ID toward the core and performs the claim handshake on core acknowledge.
- Maintains the active-level nesting stack that drives the generator's active-level comparison input (via CSR).
- Converts core end-of-interrupt into a stack pop and an EOI pulse back to the controller.

Parameters:
NEST_DEPTH, 4, maximum number of nested (preempted) active interrupts held on the stack (legal 1..8)
TIMEOUT_CYC, 64, cycles a request may wait for acknowledge; used only when ZIC_ACK_TIMEOUT_EN is defined

Ports:
zic_clk  in  1  clock, all state on rising edge
zic_rst  in  1  asynchronous active-low reset
wdt_reset_i  in  1  synchronous clear of all state to reset values
irq_req_i  in  1  request from interrupt request generator (sufficient priority, not debug)
irq_id_valid_i  in  1  generator ID valid
irq_id_i  in  8  generator interrupt ID
irq_lvl_i  in  8  level of highest pending interrupt (bits [7:5] significant)
core_ack_i  in  1  core claims presented interrupt (1-cycle pulse)
core_eoi_i  in  1  core end of interrupt (1-cycle pulse)
core_irq_o  out  1  registered interrupt request to core
core_irq_id_o  out  8  ID presented to core, stable while core_irq_o=1 except on re-arbitration
active_lvl_o  out  8  current serving level, to CSR / generator
active_id_o  out  8  current serving ID
claim_o  out  1  1-cycle pulse: clear pending bit of claim_id_o
claim_id_o  out  8  claimed ID
eoi_valid_o  out  1  1-cycle EOI pulse to controller
nest_depth_o  out  4  number of entries currently on stack (0..NEST_DEPTH)
err_o  out  1  sticky: EOI with depth 0; cleared only by reset/wdt_reset_i
timeout_o  out  1  1-cycle pulse on acknowledge timeout (0 when feature compiled out)

Behaviour:
- Reset (zic_rst low, or wdt_reset_i high at clock edge):
  - All outputs 0; state IDLE; depth 0; stack entries 0.
  - Asserting reset mid-handshake drops core_irq_o immediately (async) or next edge (wdt).
- Stack: NEST_DEPTH entries of {lvl[7:0], id[7:0]}, LIFO; base context is lvl 0 / id 0.
- FSM states: IDLE, REQ, CLAIM.
  - IDLE:
    - If irq_req_i & irq_id_valid_i & depth<NEST_DEPTH: latch irq_id_i/irq_lvl_i, core_irq_o<=1, go REQ. core_irq_o rises one cycle after the request.
    - If depth==NEST_DEPTH: no request is raised; remain IDLE.
  - REQ:
    - core_ack_i=1: push {active_lvl_o, active_id_o}; active_lvl_o/active_id_o <= latched lvl/id; depth+1; claim_o=1 and claim_id_o=latched id in next cycle; core_irq_o<=0; go CLAIM. Ack is always for the ID currently on core_irq_id_o.
    - No ack, irq_req_i=0: core_irq_o<=0, go IDLE (request withdrawn, e.g. debug entry or level change).
    - No ack, irq_req_i=1, irq_id_i differs from latch: re-latch id/lvl (higher-priority re-arbitration); core_irq_id_o updates next cycle; stay REQ.
  - CLAIM: one blanking cycle so the pending clear and new active level settle; claim_o deasserts; go IDLE.
- EOI handling, evaluated in any state:
  - core_eoi_i with depth>0: pop top into active_lvl_o/active_id_o; depth-1; eoi_valid_o pulse next cycle.
  - core_eoi_i with depth==0: ignored, no eoi_valid_o; err_o<=1.
  - core_eoi_i and core_ack_i in the same cycle (REQ): pop then push. Net result: stack and depth unchanged, active = new ID; both eoi_valid_o and claim_o pulse.
- Request and claim_o/eoi_valid_o are registered outputs; no combinational path from core inputs to outputs.

Optional Feature:
ZIC_ACK_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to REQ and counts each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYC-1: core_irq_o<=0, timeout_o pulses 1 cycle, go IDLE. A new request may be raised from IDLE on the next cycle.
  - Ack on the terminal count cycle wins over the timeout.
- Not defined: counter absent; REQ waits indefinitely; timeout_o tied 0.

Test Plan:
- Reset/basic claim:
  - Stimulus: reset; irq_req_i=1, id=0x05, lvl=0x60 at cycle 0; core_ack_i at cycle 3.
  - Required: core_irq_o=1 cycles 1-3; at cycle 4 active_lvl_o=0x60, active_id_o=0x05, claim_o=1, claim_id_o=0x05, nest_depth_o=1; IDLE at cycle 5.
- Nesting/EOI:
  - Stimulus: claim id 0x05 lvl 0x60, then id 0x09 lvl 0xA0; two EOIs.
  - Required: depth 2 then 1 then 0; active_lvl_o 0xA0 -> 0x60 -> 0x00; eoi_valid_o one pulse per EOI.
- Re-arbitration/withdraw:
  - Stimulus: in REQ, irq_id_i changes 0x05->0x07, then ack.
  - Required: core_irq_id_o=0x07 one cycle after the change; claim_id_o=0x07.
  - Stimulus: separately, drop irq_req_i in REQ.
  - Required: core_irq_o=0 next cycle, no claim_o.
- Boundaries:
  - Stimulus: fill to NEST_DEPTH=4, then assert irq_req_i.
  - Required: core_irq_o stays 0.
  - Stimulus: EOI at depth 0.
  - Required: err_o=1 sticky, no eoi_valid_o.
  - Stimulus: ack+EOI same cycle at depth 2.
  - Required: depth stays 2, active = new ID, both pulses.
- Timeout (macro on, TIMEOUT_CYC=64):
  - Stimulus: no ack.
  - Required: core_irq_o drops after 64 REQ cycles, timeout_o pulses once.
  - Stimulus: ack on cycle 64.
  - Required: claim, no timeout.
- wdt_reset_i during REQ at depth 3.
  - Required: next cycle all outputs 0, depth 0, err_o 0.
